scheduler_spawnout: RTL and testbench

- Task-spawn writer of the OmpSs@FPGA manager scheduler.
- On a start request from the scheduler FSM, it checks the next slot of the spawn-out ring queue (64-bit-word BRAM) and rejects if the slot is occupied.
- Otherwise it writes the task entry: IDs, type, then the dep/copy/arg words from the input stream, and publishes the header word last.
- It returns ok/reject to the scheduler.

---
 rtl/scheduler_spawnout.sv | 136 +++++++++++++
 tb/tb_scheduler_spawnout.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/scheduler_spawnout.sv
// Spawn-out queue writer: checks the next ring slot, writes IDs, type word and
// streamed dep/copy/arg words, then publishes the header word last.
module scheduler_spawnout #(
  parameter int QUEUE_LEN     = 1024,
  parameter int ARCHBITS_BITS = 2,
  parameter int TASKTYPE_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              spawnout_queue_addr,
  output logic                     spawnout_queue_en,
  output logic [7:0]               spawnout_queue_we,
  output logic [63:0]              spawnout_queue_din,
  input  logic [63:0]              spawnout_queue_dout,
  input  logic                     inStream_TVALID,
  output logic                     inStream_spawnout_TREADY,
  input  logic [63:0]              taskID,
  input  logic [63:0]              pTaskID,
  input  logic [TASKTYPE_BITS-1:0] task_type,
  input  logic [ARCHBITS_BITS-1:0] task_arch,
  input  logic [3:0]               num_args,
  input  logic [3:0]               num_cops,
  input  logic [3:0]               num_deps,
  input  logic [63:0]              inStream_data_buf,
  input  logic                     inStream_last_buf,
  input  logic                     spawnout_state_start,
  output logic [1:0]               spawnout_ret
);
  localparam int IW = $clog2(QUEUE_LEN);

  typedef enum logic [2:0] {
    IDLE, READ_HDR, CHECK, WR_TASKID, WR_PTASKID, WR_TYPE, WR_DATA, WR_HDR
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] wptr_q, wptr_d;
  logic [6:0]    rem_q, rem_d;
  logic [1:0]    ret_q, ret_d;
  logic [IW-1:0] idx;
  logic [6:0]    tot;
  logic [63:0]   type_w, hdr_w;

  // Payload words that follow the fixed 4-word prefix
  assign tot = 7'(num_deps) + 7'(num_cops) * 7'd3 + 7'(num_args);

  always_comb begin
    type_w = '0;
    type_w[TASKTYPE_BITS-1:0]  = task_type;
    type_w[32 +: ARCHBITS_BITS] = task_arch;
  end

  assign hdr_w = {1'b1, 31'b0, 4'b0, num_cops, 4'b0, num_deps, 4'b0, num_args, 8'b0};

  assign spawnout_queue_addr = 32'({idx, 3'b000});
  assign spawnout_ret        = ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      wptr_q   <= '0;
      rem_q    <= '0;
      ret_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      wptr_q   <= wptr_d;
      rem_q    <= rem_d;
      ret_q    <= ret_d;
    end
  end

  always_comb begin
    state_d                  = state_q;
    wr_idx_d                 = wr_idx_q;
    wptr_d                   = wptr_q;
    rem_d                    = rem_q;
    ret_d                    = 2'd0;
    idx                      = wr_idx_q;
    spawnout_queue_en        = 1'b0;
    spawnout_queue_we        = 8'h00;
    spawnout_queue_din       = '0;
    inStream_spawnout_TREADY = 1'b0;
    unique case (state_q)
      IDLE: if (spawnout_state_start) state_d = READ_HDR;
      READ_HDR: begin
        spawnout_queue_en = 1'b1;
        state_d           = CHECK;
      end
      CHECK: begin
        if (spawnout_queue_dout[63]) begin
          ret_d   = 2'd2;
          state_d = IDLE;
        end else begin
          wptr_d  = wr_idx_q + IW'(1);
          rem_d   = tot;
          state_d = WR_TASKID;
        end
      end
      WR_TASKID, WR_PTASKID, WR_TYPE: begin
        spawnout_queue_en  = 1'b1;
        spawnout_queue_we  = 8'hFF;
        idx                = wptr_q;
        wptr_d             = wptr_q + IW'(1);
        spawnout_queue_din = (state_q == WR_TASKID)  ? taskID :
                             (state_q == WR_PTASKID) ? pTaskID : type_w;
        if (state_q == WR_TASKID)       state_d = WR_PTASKID;
        else if (state_q == WR_PTASKID) state_d = WR_TYPE;
        else                            state_d = (tot != 7'd0) ? WR_DATA : WR_HDR;
      end
      WR_DATA: begin
        inStream_spawnout_TREADY = 1'b1;
        idx                      = wptr_q;
        spawnout_queue_din       = inStream_data_buf;
        if (inStream_TVALID) begin
          spawnout_queue_en = 1'b1;
          spawnout_queue_we = 8'hFF;
          wptr_d            = wptr_q + IW'(1);
          rem_d             = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = WR_HDR;
        end
      end
      WR_HDR: begin
        // wptr_q now sits one past the last payload word: the next entry
        spawnout_queue_en  = 1'b1;
        spawnout_queue_we  = 8'hFF;
        spawnout_queue_din = hdr_w;
        wr_idx_d           = wptr_q;
        ret_d              = 2'd1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_scheduler_spawnout.sv
// Directed + randomized bench for scheduler_spawnout with a BRAM model and a
// queue-level reference model of entry layout and ring index.
module tb_scheduler_spawnout;
  localparam int QL = 1024;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] q_addr;
  logic        q_en;
  logic [7:0]  q_we;
  logic [63:0] q_din, q_dout;
  logic        tvalid = 1'b0, tready;
  logic [63:0] tid = '0, ptid = '0, sdata = '0;
  logic [31:0] ttype = '0;
  logic [1:0]  tarch = '0;
  logic [3:0]  n_args = '0, n_cops = '0, n_deps = '0;
  logic        start = 1'b0;
  logic [1:0]  ret;

  scheduler_spawnout dut (
    .clk(clk), .rst(rst),
    .spawnout_queue_addr(q_addr), .spawnout_queue_en(q_en),
    .spawnout_queue_we(q_we), .spawnout_queue_din(q_din),
    .spawnout_queue_dout(q_dout),
    .inStream_TVALID(tvalid), .inStream_spawnout_TREADY(tready),
    .taskID(tid), .pTaskID(ptid), .task_type(ttype), .task_arch(tarch),
    .num_args(n_args), .num_cops(n_cops), .num_deps(n_deps),
    .inStream_data_buf(sdata), .inStream_last_buf(1'b0),
    .spawnout_state_start(start), .spawnout_ret(ret)
  );

  // BRAM model with 1-cycle read latency; clr_all models the consumer draining the ring
  logic [63:0] mem [QL];
  logic        clr_all = 1'b0, seed_req = 1'b0;
  logic [9:0]  seed_idx = '0;
  logic [63:0] seed_val = '0;
  always @(posedge clk) begin
    if (clr_all) begin
      for (int i = 0; i < QL; i++) mem[i] <= '0;
    end else if (seed_req) begin
      mem[seed_idx] <= seed_val;
    end
    if (q_en) begin
      if (q_we != 8'h00) begin
        for (int b = 0; b < 8; b++)
          if (q_we[b]) mem[q_addr[12:3]][8*b +: 8] <= q_din[8*b +: 8];
      end else begin
        q_dout <= mem[q_addr[12:3]];
      end
    end
  end

  int tests = 0, fails = 0;
  int exp_widx = 0;
  int last_rd = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_ids();
    tid   = {$urandom, $urandom};
    ptid  = {$urandom, $urandom};
    ttype = $urandom;
    tarch = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; tvalid = 1'b0; clr_all = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; clr_all = 1'b0;
    #1;
    chk("rst_en", 64'(q_en), 64'd0);
    chk("rst_we", 64'(q_we), 64'd0);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_ret", 64'(ret), 64'd0);
    exp_widx = 0;
  endtask

  task automatic bram_seed(input int idx, input logic [63:0] val);
    @(negedge clk);
    clr_all = 1'b0; seed_req = 1'b1; seed_idx = 10'(idx); seed_val = val;
    @(negedge clk);
    seed_req = 1'b0;
  endtask

  // One spawn request; the model predicts the full ordered write list.
  task automatic run_task(input int nd, input int nc, input int na, input bit rej,
                          input int abort_at, input int vprob);
    logic [63:0] stream[$];
    int          ea[$];
    logic [63:0] ed[$];
    int          wa[$], wc[$];
    logic [63:0] wd[$];
    logic [7:0]  wwe[$];
    int          n, base, sptr, ret_cyc, rd_addr;
    logic [1:0]  retv;
    bit          in_data;
    logic [63:0] typew, hdr;

    n = nd + 3*nc + na;
    for (int i = 0; i < n; i++) stream.push_back({$urandom, $urandom});
    base = exp_widx;
    typew = (64'(tarch) << 32) | 64'(ttype);
    hdr = (64'd1 << 63) | (64'(nc) << 24) | (64'(nd) << 16) | (64'(na) << 8);
    if (!rej) begin
      ea.push_back((base + 1) % QL); ed.push_back(tid);
      ea.push_back((base + 2) % QL); ed.push_back(ptid);
      ea.push_back((base + 3) % QL); ed.push_back(typew);
      for (int i = 0; i < n; i++) begin
        ea.push_back((base + 4 + i) % QL); ed.push_back(stream[i]);
      end
      ea.push_back(base); ed.push_back(hdr);
    end

    @(negedge clk);
    clr_all = 1'b0;
    n_deps = 4'(nd); n_cops = 4'(nc); n_args = 4'(na);
    start = 1'b1; tvalid = 1'b0;
    sptr = 0; ret_cyc = -1; rd_addr = -1; retv = 2'd0; in_data = 1'b0;
    for (int cyc = 1; cyc < 400 && ret_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_at >= 0 && in_data && sptr == abort_at) begin
        tvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_en", 64'(q_en), 64'd0);
        chk("abort_ret", 64'(ret), 64'd0);
        chk("abort_tready", 64'(tready), 64'd0);
        exp_widx = 0;
        return;
      end
      tvalid = ($urandom_range(0, 99) < vprob);
      sdata  = (sptr < n) ? stream[sptr] : {$urandom, $urandom};
      #1;
      if (q_en && q_we == 8'h00 && rd_addr < 0) rd_addr = int'(q_addr);
      if (q_en && q_we != 8'h00) begin
        wa.push_back(int'(q_addr)); wd.push_back(q_din); wc.push_back(cyc); wwe.push_back(q_we);
      end
      if (tready && tvalid) sptr++;
      in_data = tready;
      if (ret != 2'd0) begin ret_cyc = cyc; retv = ret; end
    end

    chk("ret_code", 64'(retv), rej ? 64'd2 : 64'd1);
    chk("read_addr", 64'(rd_addr), 64'(base * 8));
    chk("consumed", 64'(sptr), rej ? 64'd0 : 64'(n));
    chk("write_count", 64'(wa.size()), 64'(ea.size()));
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), 64'(wa[i]), 64'(ea[i] * 8));
      chk($sformatf("wr_data[%0d]", i), wd[i], ed[i]);
      chk($sformatf("wr_we[%0d]", i), 64'(wwe[i]), 64'hFF);
    end
    if (rej) chk("rej_ret_cycle", 64'(ret_cyc), 64'd3);
    else if (wc.size() > 0) begin
      chk("first_wr_cycle", 64'(wc[0]), 64'd3);
      chk("ok_ret_cycle", 64'(ret_cyc), 64'(wc[wc.size()-1] + 1));
    end

    @(negedge clk);
    tvalid = 1'b0; clr_all = 1'b1;
    #1;
    chk("ret_pulse", 64'(ret), 64'd0);
    chk("idle_tready", 64'(tready), 64'd0);
    last_rd = rd_addr;
    if (!rej) exp_widx = (base + 4 + n) % QL;
  endtask

  initial begin
    int rem, nd, nc, na, r;
    do_reset();

    // zero-length task with the fixed IDs
    bram_seed(0, 64'h00DDEEAADDBBEEFF);
    tid = 64'h1234567887654321; ptid = 64'h8765432112345678;
    ttype = 32'h11223344; tarch = 2'd3;
    run_task(0, 0, 0, 1'b0, -1, 100);

    // occupied slot at wr_idx=4
    rand_ids();
    bram_seed(4, 64'h8000_0000_0000_0000 | {32'd0, $urandom});
    run_task(2, 1, 1, 1'b1, -1, 100);
    rand_ids();
    run_task(1, 0, 0, 1'b0, -1, 100);
    chk("after_reject_addr", 64'(last_rd), 64'h20);

    // streamed payload with toggling TVALID, then back-to-back tasks
    do_reset();
    rand_ids();
    run_task(1, 1, 2, 1'b0, -1, 50);
    rand_ids();
    run_task(0, 2, 1, 1'b0, -1, 50);
    chk("second_task_addr", 64'(last_rd), 64'h50);
    for (int k = 0; k < 4; k++) begin
      rand_ids();
      run_task($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, -1, 70);
    end

    // reset in the middle of the payload
    rand_ids();
    run_task(5, 0, 0, 1'b0, 2, 100);
    bram_seed(0, 64'd0);
    @(negedge clk); clr_all = 1'b1;
    rand_ids();
    run_task(0, 1, 0, 1'b0, -1, 80);
    chk("post_abort_addr", 64'(last_rd), 64'h0);

    // advance the ring to QUEUE_LEN-2, then a 6-word wrapping entry
    while (exp_widx != QL - 2) begin
      rem = (QL - 2 - exp_widx + QL) % QL;
      if (rem >= 72) begin nd = 15; nc = 15; na = 4; end
      else begin
        r  = rem - 4;
        nd = (r < 15) ? r : 15; r -= nd;
        nc = (r / 3 < 15) ? r / 3 : 15; r -= 3 * nc;
        na = r;
      end
      rand_ids();
      run_task(nd, nc, na, 1'b0, -1, 90);
    end
    rand_ids();
    run_task(1, 0, 1, 1'b0, -1, 60);
    rand_ids();
    run_task(0, 0, 2, 1'b0, -1, 60);
    chk("wrap_next_addr", 64'(last_rd), 64'h20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
